// File: rtl/mmio_uart_tx.sv
// Memory-mapped debug UART: snoops CPU stores to MMIO_ADDR, queues the low byte in a
// FIFO and drains it as 8N1 frames. The CPU is never stalled; overflowing stores are counted.
module mmio_uart_tx #(
    parameter logic [31:0] MMIO_ADDR    = 32'h0000_7F00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         MemWrite,
    input  logic [31:0]                  mem_addr,
    input  logic [31:0]                  wdata,
    output logic                         tx,
    output logic                         busy,
    output logic                         fifo_full,
    output logic                         fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic [7:0]                   drop_cnt,
    output logic                         tx_done
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              BCW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BCW-1:0]  BC_LAST   = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0]  BC_ONE    = BCW'(1);
    localparam logic [BCW-1:0]  BC_ZERO   = BCW'(0);
    localparam logic [AW:0]     DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]     CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]     CNT_ZERO  = (AW + 1)'(0);
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
    localparam logic [AW-1:0]   PTR_ZERO  = AW'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_r, state_n_s;
    logic [BCW-1:0]  bc_r, bc_n_s;
    logic [2:0]      bit_idx_r, bit_idx_n_s;
    logic [7:0]      shift_r, shift_n_s;
    logic            tx_r, tx_n_s;
    logic            tx_done_r, tx_done_n_s;
    logic            busy_r;
    logic [7:0]      fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [AW:0]     count_r, count_n_s;
    logic            full_r, empty_r;
    logic [7:0]      drop_cnt_r;
    logic            hit_s, pop_s, push_s, bc_last_s;
    logic            unused_wdata_s;

    assign unused_wdata_s = ^wdata[31:8];

    // A store to a full FIFO still lands if the transmitter frees a slot in the same cycle.
    assign hit_s     = MemWrite && (mem_addr == MMIO_ADDR);
    assign pop_s     = (state_r == IDLE) && !empty_r;
    assign push_s    = hit_s && (!full_r || pop_s);
    assign bc_last_s = (bc_r == BC_LAST);

    // FIFO occupancy next value
    always_comb begin
        count_n_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_n_s = count_r + CNT_ONE;
            2'b01:   count_n_s = count_r - CNT_ONE;
            default: count_n_s = count_r;
        endcase
    end

    // UART framing: next state, bit timer, shifter and line level
    always_comb begin
        state_n_s   = state_r;
        bc_n_s      = bc_r;
        bit_idx_n_s = bit_idx_r;
        shift_n_s   = shift_r;
        tx_n_s      = tx_r;
        case (state_r)
            IDLE: begin
                bc_n_s = BC_ZERO;
                if (pop_s) begin
                    state_n_s = START;
                    shift_n_s = fifo_mem_r[rd_ptr_r];
                    tx_n_s    = 1'b0;
                end else begin
                    state_n_s = IDLE;
                    tx_n_s    = 1'b1;
                end
            end
            START: begin
                if (bc_last_s) begin
                    state_n_s   = DATA;
                    bc_n_s      = BC_ZERO;
                    bit_idx_n_s = 3'd0;
                    tx_n_s      = shift_r[0];
                    shift_n_s   = {1'b0, shift_r[7:1]};
                end else begin
                    bc_n_s = bc_r + BC_ONE;
                end
            end
            DATA: begin
                if (bc_last_s) begin
                    bc_n_s = BC_ZERO;
                    if (bit_idx_r == 3'd7) begin
                        state_n_s = STOP;
                        tx_n_s    = 1'b1;
                    end else begin
                        bit_idx_n_s = bit_idx_r + 3'd1;
                        tx_n_s      = shift_r[0];
                        shift_n_s   = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    bc_n_s = bc_r + BC_ONE;
                end
            end
            STOP: begin
                if (bc_last_s) begin
                    state_n_s = IDLE;
                    bc_n_s    = BC_ZERO;
                    tx_n_s    = 1'b1;
                end else begin
                    bc_n_s = bc_r + BC_ONE;
                end
            end
            default: begin
                state_n_s = IDLE;
                bc_n_s    = BC_ZERO;
                tx_n_s    = 1'b1;
            end
        endcase
        // Registered so that the pulse coincides with the final STOP cycle.
        tx_done_n_s = (state_n_s == STOP) && (bc_n_s == BC_LAST);
    end

    // FSM, FIFO control and drop counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            bc_r       <= BC_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
            tx_done_r  <= 1'b0;
            busy_r     <= 1'b0;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            drop_cnt_r <= 8'h00;
        end else begin
            state_r   <= state_n_s;
            bc_r      <= bc_n_s;
            bit_idx_r <= bit_idx_n_s;
            shift_r   <= shift_n_s;
            tx_r      <= tx_n_s;
            tx_done_r <= tx_done_n_s;
            busy_r    <= (state_n_s != IDLE);
            count_r   <= count_n_s;
            full_r    <= (count_n_s == DEPTH_CNT);
            empty_r   <= (count_n_s == CNT_ZERO);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (hit_s && !push_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            fifo_mem_r[wr_ptr_r] <= wdata[7:0];
        end
    end

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign fifo_full  = full_r;
    assign fifo_empty = empty_r;
    assign fifo_count = count_r;
    assign drop_cnt   = drop_cnt_r;
    assign tx_done    = tx_done_r;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed stores feed an expected-byte queue; a UART receiver
// process decodes every frame on tx and checks it against the queue head.
module tb_mmio_uart_tx;

    localparam logic [31:0] MMIO = 32'h0000_7F00;
    localparam int          CPB  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] wdata;
    logic        tx, busy, fifo_full, fifo_empty, tx_done;
    logic [3:0]  fifo_count;
    logic [7:0]  drop_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q [$];
    bit          period_chk = 1'b0;
    bit          prev_valid = 1'b0;
    int          spurious_done = 0;

    mmio_uart_tx dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (mem_write),
        .mem_addr   (mem_addr),
        .wdata      (wdata),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [7:0] d);
        mem_write = 1'b1;
        mem_addr  = a;
        wdata     = {24'hC0FFEE, d};
        tick();
        mem_write = 1'b0;
    endtask

    task automatic wait_not_busy(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check("idle_timeout", 32'(k < budget), 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy || !fifo_empty) && k < budget) begin
            tick();
            k++;
        end
        check("drain_timeout", 32'(k < budget), 32'd1);
    endtask

    // Receiver: checks every cycle of each frame against the expected line level
    initial begin
        int         cyc = 0;
        int         prev_start = 0;
        bit         act = 1'b0;
        int         off = 0;
        int         pos;
        int         line_err = 0;
        logic       lvl;
        logic [7:0] exp_b = 8'h00;
        logic [7:0] got_b = 8'h00;
        logic [7:0] head;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                act = 1'b0;
            end else begin
                if (!act) begin
                    if (tx_done) spurious_done++;
                    if (tx == 1'b0) begin
                        act      = 1'b1;
                        off      = 0;
                        line_err = 0;
                        got_b    = 8'h00;
                        exp_b    = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
                        if (period_chk && prev_valid) check("frame_period", cyc - prev_start, 32'd161);
                        prev_start = cyc;
                        prev_valid = 1'b1;
                    end
                end
                if (act) begin
                    pos = off / CPB;
                    if (pos == 0)      lvl = 1'b0;
                    else if (pos == 9) lvl = 1'b1;
                    else               lvl = exp_b[pos-1];
                    if (tx !== lvl) line_err++;
                    if (pos >= 1 && pos <= 8 && (off % CPB) == CPB / 2) got_b[pos-1] = tx;
                    if (off == 10 * CPB - 1) begin
                        check("tx_done_at_stop_end", tx_done, 1'b1);
                        check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                        if (exp_q.size() > 0) begin
                            head = exp_q.pop_front();
                            check("frame_byte", got_b, head);
                        end
                        check("frame_line_errors", line_err, 32'd0);
                        act = 1'b0;
                    end else if (tx_done) begin
                        spurious_done++;
                    end
                    off++;
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        wdata     = 32'h0;
        tick();
        tick();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 4'd0);
        check("rst_empty", fifo_empty, 1'b1);
        check("rst_full", fifo_full, 1'b0);
        check("rst_drop", drop_cnt, 8'h00);
        check("rst_tx_done", tx_done, 1'b0);
        reset = 1'b0;
        tick();

        // Single byte: stored at the store edge, popped one edge later
        exp_q.push_back(8'hA5);
        store(MMIO, 8'hA5);
        check("t1_tx_at_store", tx, 1'b1);
        check("t1_count_at_store", fifo_count, 4'd1);
        tick();
        check("t1_tx_falls", tx, 1'b0);
        check("t1_busy", busy, 1'b1);
        check("t1_count_after_pop", fifo_count, 4'd0);
        wait_drain(400);

        // Non-matching addresses and a read at the MMIO address are ignored
        store(MMIO + 32'd4, 8'h3C);
        store(32'h0, 8'h3C);
        mem_addr = MMIO;
        repeat (3) tick();
        check("t2_tx", tx, 1'b1);
        check("t2_count", fifo_count, 4'd0);
        check("t2_drop", drop_cnt, 8'h00);
        check("t2_busy", busy, 1'b0);

        // Burst of ten: first pops at once, eight fill the FIFO, the tenth is dropped
        prev_valid = 1'b0;
        period_chk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_q.push_back(8'h10 + 8'(i * 17));
            store(MMIO, 8'h10 + 8'(i * 17));
        end
        check("t3_full", fifo_full, 1'b1);
        check("t3_count", fifo_count, 4'd8);
        check("t3_drop", drop_cnt, 8'd1);

        // Store on the pop edge of a full FIFO is accepted
        wait_not_busy(400);
        check("t4_count_before", fifo_count, 4'd8);
        exp_q.push_back(8'hE7);
        store(MMIO, 8'hE7);
        check("t4_count", fifo_count, 4'd8);
        check("t4_full", fifo_full, 1'b1);
        check("t4_drop", drop_cnt, 8'd1);
        check("t4_tx_start", tx, 1'b0);
        wait_drain(2500);
        period_chk = 1'b0;

        // 309 stores: ten are accepted (one at the second pop), 299 drops saturate
        for (int i = 0; i < 10; i++) exp_q.push_back(8'h5A);
        for (int i = 0; i < 309; i++) store(MMIO, 8'h5A);
        check("t6_drop_sat", drop_cnt, 8'hFF);
        check("t6_full", fifo_full, 1'b1);
        store(MMIO, 8'h5A);
        check("t6_drop_hold", drop_cnt, 8'hFF);

        // Reset in the middle of DATA bit 3 aborts the frame and flushes the FIFO
        wait_not_busy(400);
        tick();
        check("t5_frame_start", tx, 1'b0);
        repeat (70) tick();
        check("t5_mid_frame_busy", busy, 1'b1);
        reset = 1'b1;
        exp_q.delete();
        tick();
        check("t5_tx", tx, 1'b1);
        check("t5_busy", busy, 1'b0);
        check("t5_count", fifo_count, 4'd0);
        check("t5_empty", fifo_empty, 1'b1);
        check("t5_drop", drop_cnt, 8'h00);
        reset = 1'b0;
        tick();
        exp_q.push_back(8'hC3);
        store(MMIO, 8'hC3);
        tick();
        check("t5_new_frame_start", tx, 1'b0);
        wait_drain(400);

        check("no_stray_tx_done", spurious_done, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
